dtype_conv_arbiter: RTL and testbench

DTYPE_CONV_ARBITER -- requirements
Module: dtype_conv_arbiter

---
 rtl/dtype_pkg.sv | 58 +++++
 rtl/dtype_converter.sv | 53 +++++
 rtl/dtype_conv_arbiter.sv | 106 ++++++++++
 tb/tb_dtype_conv_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dtype_pkg.sv
// Shared type codes, widths and signed range limits for the dtype converter/arbiter.
// Clamping limits are only consumed when DTYPE_CONV_SATURATE_EN is defined.
package dtype_pkg;

    localparam int unsigned W_BYTE     = 8;
    localparam int unsigned W_SHORTINT = 16;
    localparam int unsigned W_INT      = 32;
    localparam int unsigned W_LONGINT  = 64;

    typedef enum logic [1:0] {
        DT_BYTE     = 2'd0,
        DT_SHORTINT = 2'd1,
        DT_INT      = 2'd2,
        DT_LONGINT  = 2'd3
    } dtype_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam logic signed [63:0] BYTE_MIN     = -64'sd128;
    localparam logic signed [63:0] BYTE_MAX     =  64'sd127;
    localparam logic signed [63:0] SHORTINT_MIN = -64'sd32768;
    localparam logic signed [63:0] SHORTINT_MAX =  64'sd32767;
    localparam logic signed [63:0] INT_MIN      = -64'sd2147483648;
    localparam logic signed [63:0] INT_MAX      =  64'sd2147483647;
    localparam logic signed [63:0] LONGINT_MIN  =  64'sh8000_0000_0000_0000;
    localparam logic signed [63:0] LONGINT_MAX  =  64'sh7FFF_FFFF_FFFF_FFFF;

    function automatic int unsigned dtype_width(input dtype_e t);
        case (t)
            DT_BYTE:     return W_BYTE;
            DT_SHORTINT: return W_SHORTINT;
            DT_INT:      return W_INT;
            default:     return W_LONGINT;
        endcase
    endfunction

    function automatic logic signed [63:0] dtype_min(input dtype_e t);
        case (t)
            DT_BYTE:     return BYTE_MIN;
            DT_SHORTINT: return SHORTINT_MIN;
            DT_INT:      return INT_MIN;
            default:     return LONGINT_MIN;
        endcase
    endfunction

    function automatic logic signed [63:0] dtype_max(input dtype_e t);
        case (t)
            DT_BYTE:     return BYTE_MAX;
            DT_SHORTINT: return SHORTINT_MAX;
            DT_INT:      return INT_MAX;
            default:     return LONGINT_MAX;
        endcase
    endfunction

endpackage

// File: rtl/dtype_converter.sv
// Combinational integer type converter: sign-extend source, then fit to destination.
// DTYPE_CONV_SATURATE_EN selects clamping; otherwise the result wraps.
module dtype_converter
    import dtype_pkg::*;
(
    input  logic [63:0] data,
    input  dtype_e      src_type,
    input  dtype_e      dst_type,
    output logic [63:0] result,
    output logic        sat
);

    logic signed [63:0] src_val;
    logic signed [63:0] wrap_val;

    // Interpret only the low source-width bits as a signed value.
    always_comb begin
        case (src_type)
            DT_BYTE:     src_val = {{56{data[7]}},  data[7:0]};
            DT_SHORTINT: src_val = {{48{data[15]}}, data[15:0]};
            DT_INT:      src_val = {{32{data[31]}}, data[31:0]};
            default:     src_val = data;
        endcase
    end

    // Truncate to destination width; a no-op whenever the destination is not narrower.
    always_comb begin
        case (dst_type)
            DT_BYTE:     wrap_val = {{56{src_val[7]}},  src_val[7:0]};
            DT_SHORTINT: wrap_val = {{48{src_val[15]}}, src_val[15:0]};
            DT_INT:      wrap_val = {{32{src_val[31]}}, src_val[31:0]};
            default:     wrap_val = src_val;
        endcase
    end

`ifdef DTYPE_CONV_SATURATE_EN
    always_comb begin
        result = wrap_val;
        sat    = 1'b0;
        if (src_val > dtype_max(dst_type)) begin
            result = dtype_max(dst_type);
            sat    = 1'b1;
        end else if (src_val < dtype_min(dst_type)) begin
            result = dtype_min(dst_type);
            sat    = 1'b1;
        end
    end
`else
    assign result = wrap_val;
    assign sat    = 1'b0;
`endif

endmodule

// File: rtl/dtype_conv_arbiter.sv
// Round-robin arbiter sharing one dtype converter, with a single registered result slot.
// DTYPE_CONV_SATURATE_EN enables clamping and the saturation-event counter.
module dtype_conv_arbiter
    import dtype_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned CNT_W   = 16,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ-1:0][63:0] req_data_i,
    input  logic [NUM_REQ-1:0][1:0]  req_src_type_i,
    input  logic [NUM_REQ-1:0][1:0]  req_dst_type_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [63:0]              out_data_o,
    output logic [ID_W-1:0]          out_id_o,
    output logic                     out_sat_o,
    output logic [CNT_W-1:0]         sat_cnt_o
);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_found;
    int unsigned      cand;
    logic             can_take;
    logic             accept;
    logic             handshake;
    logic [63:0]      conv_result;
    logic             conv_sat;

    // First asserted request at or above ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(ptr_q) + k) % NUM_REQ;
            if (!grant_found && req_valid_i[ID_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    // The slot can take a new result if empty or being drained this cycle.
    assign can_take    = rst_ni && ((state_q == IDLE) || out_ready_i);
    assign accept      = grant_found && can_take;
    assign req_ready_o = accept ? (NUM_REQ'(1) << grant_idx) : '0;
    assign handshake   = out_valid_o && out_ready_i;

    dtype_converter u_conv (
        .data     (req_data_i[grant_idx]),
        .src_type (dtype_e'(req_src_type_i[grant_idx])),
        .dst_type (dtype_e'(req_dst_type_i[grant_idx])),
        .result   (conv_result),
        .sat      (conv_sat)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (out_ready_i && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_id_o    <= '0;
            out_sat_o   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_o <= (state_d == BUSY);
            if (accept) begin
                ptr_q      <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                out_data_o <= conv_result;
                out_id_o   <= grant_idx;
                out_sat_o  <= conv_sat;
            end
        end
    end

`ifdef DTYPE_CONV_SATURATE_EN
    // Counts clamped results as they leave; sticks at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sat_cnt_o <= '0;
        end else if (handshake && out_sat_o && (sat_cnt_o != '1)) begin
            sat_cnt_o <= sat_cnt_o + CNT_W'(1);
        end
    end
`else
    assign sat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dtype_conv_arbiter.sv
// Bench for dtype_conv_arbiter: directed vectors plus a per-cycle reference model.
// Follows DTYPE_CONV_SATURATE_EN to pick clamping or wrapping expectations.
module tb_dtype_conv_arbiter;

`ifdef DTYPE_CONV_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int N  = 4;
    localparam int CW = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N-1:0][63:0]  req_data;
    logic [N-1:0][1:0]   req_src;
    logic [N-1:0][1:0]   req_dst;
    logic                out_valid;
    logic                out_ready;
    logic [63:0]         out_data;
    logic [1:0]          out_id;
    logic                out_sat;
    logic [CW-1:0]       sat_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dtype_conv_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_data_i     (req_data),
        .req_src_type_i (req_src),
        .req_dst_type_i (req_dst),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_data_o     (out_data),
        .out_id_o       (out_id),
        .out_sat_o      (out_sat),
        .sat_cnt_o      (sat_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Arithmetic reference: shift-based sign extension and explicit range clamp.
    function automatic longint sext(input longint v, input int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    task automatic convert(input logic [63:0] d, input logic [1:0] st, input logic [1:0] dt,
                           output longint r, output bit s);
        int     ws;
        int     wd;
        longint v;
        longint mx;
        longint mn;
        ws = 8 << st;
        wd = 8 << dt;
        v  = sext(longint'(d), ws);
        r  = v;
        s  = 1'b0;
        if (wd < ws) begin
            if (SAT) begin
                mx = (longint'(1) <<< (wd - 1)) - 1;
                mn = -mx - 1;
                if (v > mx) begin r = mx; s = 1'b1; end
                else if (v < mn) begin r = mn; s = 1'b1; end
            end else begin
                r = sext(v, wd);
            end
        end
    endtask

    // Model state describes the outputs expected after the next rising edge.
    int          m_ptr   = 0;
    bit          m_valid = 1'b0;
    logic [63:0] m_data  = '0;
    int          m_id    = 0;
    bit          m_sat   = 1'b0;
    int          m_cnt   = 0;

    always @(negedge clk) begin : model
        int         g;
        int         idx;
        bit         found;
        bit         can_t;
        bit         hs;
        logic [3:0] er;
        longint     r;
        bit         s;
        if (!rst_n) begin
            m_ptr = 0; m_valid = 1'b0; m_data = '0; m_id = 0; m_sat = 1'b0; m_cnt = 0;
            chk("rst_out_valid", 64'(out_valid), 64'(0));
            chk("rst_req_ready", 64'(req_ready), 64'(0));
            chk("rst_out_data", out_data, 64'(0));
            chk("rst_sat_cnt", 64'(sat_cnt), 64'(0));
        end else begin
            chk("m_out_valid", 64'(out_valid), 64'(m_valid));
            if (m_valid) begin
                chk("m_out_data", out_data, m_data);
                chk("m_out_id", 64'(out_id), 64'(m_id));
                chk("m_out_sat", 64'(out_sat), 64'(m_sat));
            end
            chk("m_sat_cnt", 64'(sat_cnt), 64'(m_cnt));
            found = 1'b0;
            g     = 0;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && req_valid[idx]) begin found = 1'b1; g = idx; end
            end
            can_t = !m_valid || out_ready;
            er    = (found && can_t) ? 4'(1 << g) : 4'b0;
            chk("m_req_ready", 64'(req_ready), 64'(er));
            hs = m_valid && out_ready;
            if (hs && m_sat && m_cnt != (1 << CW) - 1) m_cnt++;
            if (found && can_t) begin
                convert(req_data[g], req_src[g], req_dst[g], r, s);
                m_valid = 1'b1; m_data = r; m_id = g; m_sat = s; m_ptr = (g + 1) % N;
            end else if (hs) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [63:0] d, input logic [1:0] st, input logic [1:0] dt);
        req_data[i] = d;
        req_src[i]  = st;
        req_dst[i]  = dt;
    endtask

    initial begin
        int order [6];
        order = '{0, 1, 2, 3, 0, 1};
        req_valid = '0;
        req_data  = '0;
        req_src   = '0;
        req_dst   = '0;
        out_ready = 1'b1;

        // Requester 0 waits through reset: BYTE 0x9C -> LONGINT.
        set_req(0, 64'h0000_0000_0000_009C, 2'd0, 2'd3);
        req_valid = 4'b0001;
        repeat (2) step();
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_req_ready", 64'(req_ready), 64'(0));
        chk("reset_sat_cnt", 64'(sat_cnt), 64'(0));
        rst_n = 1'b1;
        #1;
        chk("release_req_ready", 64'(req_ready), 64'(4'b0001));
        step();
        chk("byte_to_long_valid", 64'(out_valid), 64'(1));
        chk("byte_to_long_data", out_data, 64'hFFFF_FFFF_FFFF_FF9C);
        chk("byte_to_long_id", 64'(out_id), 64'(0));
        chk("byte_to_long_sat", 64'(out_sat), 64'(0));

        // INT -12345678 -> BYTE from requester 2, back-to-back with the previous drain.
        set_req(2, 64'h0000_0000_FF43_9EB2, 2'd2, 2'd0);
        req_valid = 4'b0100;
        step();
        chk("int_to_byte_data", out_data, SAT ? 64'hFFFF_FFFF_FFFF_FF80 : 64'hFFFF_FFFF_FFFF_FFB2);
        chk("int_to_byte_sat", 64'(out_sat), 64'(SAT));
        chk("int_to_byte_id", 64'(out_id), 64'(2));
        req_valid = '0;
        step();
        chk("drain_valid", 64'(out_valid), 64'(0));
        chk("sat_cnt_after_one", 64'(sat_cnt), 64'(SAT ? 1 : 0));

        // Fresh pointer, then all four requesters streaming.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_req(0, 64'hDEAD_BEEF_0000_009C, 2'd0, 2'd3);
        set_req(1, 64'h0000_0000_0000_7FFF, 2'd1, 2'd0);
        set_req(2, 64'h0000_0000_FF43_9EB2, 2'd2, 2'd0);
        set_req(3, 64'h0000_0001_0000_0005, 2'd3, 2'd2);
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_valid", 64'(out_valid), 64'(1));
            chk("rr_order", 64'(out_id), 64'(order[k]));
        end

        // Backpressure holds the id1 result; a withdrawn request in between is harmless.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            req_valid = (k == 2) ? 4'b0010 : 4'b1111;
            step();
            chk("bp_id", 64'(out_id), 64'(1));
            chk("bp_data", out_data, SAT ? 64'h0000_0000_0000_007F : 64'hFFFF_FFFF_FFFF_FFFF);
            chk("bp_req_ready", 64'(req_ready), 64'(0));
        end
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(req_ready), 64'(4'b0100));
        step();
        chk("bp_release_id", 64'(out_id), 64'(2));

        // Reset while stalled: output drops at once, next grant goes to requester 0.
        out_ready = 1'b0;
        step();
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'(0));
        chk("async_rst_ready", 64'(req_ready), 64'(0));
        step();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post_rst_id", 64'(out_id), 64'(0));
        chk("post_rst_data", out_data, 64'hFFFF_FFFF_FFFF_FF9C);

        // Equal types pass through at the range boundary.
        set_req(0, 64'h0000_0000_0000_8000, 2'd1, 2'd1);
        req_valid = 4'b0001;
        step();
        chk("pass_data", out_data, 64'hFFFF_FFFF_FFFF_8000);
        chk("pass_sat", 64'(out_sat), 64'(0));

        // Twenty clamped results drive the 4-bit counter into its ceiling.
        req_valid = 4'b0010;
        repeat (20) step();
        req_valid = '0;
        repeat (2) step();
        chk("sat_cnt_ceiling", 64'(sat_cnt), 64'(SAT ? 15 : 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
